// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: shares one FP writeback port between div and sqrt; sqrt wins unless div has starved.
// Define FP_WB_ARB_SKID_EN for a registered output stage (1-cycle latency); default is combinational.
module fp_wb_arbiter #(
    parameter int ID_W         = 3,
    parameter int PAYLOAD_W    = 96,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_done,
    input  logic [ID_W-1:0]      div_id,
    input  logic [PAYLOAD_W-1:0] div_payload,
    output logic                 div_ack,
    input  logic                 sqrt_done,
    input  logic [ID_W-1:0]      sqrt_id,
    input  logic [PAYLOAD_W-1:0] sqrt_payload,
    output logic                 sqrt_ack,
    output logic                 wb_done,
    output logic [ID_W-1:0]      wb_id,
    output logic [PAYLOAD_W-1:0] wb_payload,
    output logic                 wb_src,
    input  logic                 wb_ack
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       any_done, pick_sqrt, grant;

    assign any_done  = div_done | sqrt_done;
    // div overrides sqrt once it has watched LIMIT sqrt grants go by
    assign pick_sqrt = sqrt_done && !(div_done && starve_cnt_q == LIMIT);
    assign div_ack   = grant && !pick_sqrt;
    assign sqrt_ack  = grant && pick_sqrt;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!div_done || div_ack)
            starve_cnt_d = '0;
        else if (sqrt_ack && starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end

`ifdef FP_WB_ARB_SKID_EN
    typedef enum logic {EMPTY, FULL} state_e;

    state_e               state_q, state_d;
    logic                 wb_src_q, wb_src_d;
    logic [ID_W-1:0]      wb_id_q, wb_id_d;
    logic [PAYLOAD_W-1:0] wb_payload_q, wb_payload_d;

    // gating on rst keeps both acks low while the block is held in reset
    always_comb begin
        grant        = rst && any_done && (state_q == EMPTY || wb_ack);
        state_d      = state_q;
        wb_src_d     = wb_src_q;
        wb_id_d      = wb_id_q;
        wb_payload_d = wb_payload_q;
        if (grant) begin
            state_d      = FULL;
            wb_src_d     = pick_sqrt;
            wb_id_d      = pick_sqrt ? sqrt_id : div_id;
            wb_payload_d = pick_sqrt ? sqrt_payload : div_payload;
        end else if (state_q == FULL && wb_ack) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            wb_src_q     <= 1'b0;
            wb_id_q      <= '0;
            wb_payload_q <= '0;
        end else begin
            state_q      <= state_d;
            wb_src_q     <= wb_src_d;
            wb_id_q      <= wb_id_d;
            wb_payload_q <= wb_payload_d;
        end
    end

    assign wb_done    = state_q == FULL;
    assign wb_src     = wb_src_q;
    assign wb_id      = wb_id_q;
    assign wb_payload = wb_payload_q;
`else
    assign grant      = wb_ack && any_done;
    assign wb_done    = any_done;
    assign wb_src     = pick_sqrt;
    assign wb_id      = pick_sqrt ? sqrt_id : div_id;
    assign wb_payload = pick_sqrt ? sqrt_payload : div_payload;
`endif
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed bench for fp_wb_arbiter with a per-cycle reference model.
// Works for both builds; FP_WB_ARB_SKID_EN selects the registered-output expectations.
module tb_fp_wb_arbiter;
    localparam int ID_W = 3;
    localparam int PW   = 96;
    localparam int LIM  = 4;
`ifdef FP_WB_ARB_SKID_EN
    localparam int EXP_BP_DIV = 3;
    localparam int EXP_TP_FIRST = 1;
`else
    localparam int EXP_BP_DIV = 4;
    localparam int EXP_TP_FIRST = 0;
`endif

    logic            clk = 0;
    logic            rst = 0;
    logic            div_done = 0, sqrt_done = 0, wb_ack = 0;
    logic [ID_W-1:0] div_id = '0, sqrt_id = '0;
    logic [PW-1:0]   div_payload = '0, sqrt_payload = '0;
    logic            div_ack, sqrt_ack, wb_done, wb_src;
    logic [ID_W-1:0] wb_id;
    logic [PW-1:0]   wb_payload;

    int checks = 0;
    int errors = 0;
    int div_q[$];
    int sqrt_q[$];
    bit saw_d = 0, saw_s = 0;

    // reference model state: sqrt grants seen in a row while div waited, plus the output slot
    int              streak = 0;
    bit              m_full = 0, m_src = 0;
    logic [ID_W-1:0] m_id = '0;
    logic [PW-1:0]   m_pay = '0;
    bit              any, ps, take, e_done, e_src;
    logic [ID_W-1:0] e_id;
    logic [PW-1:0]   e_pay;

    int dpos[$];
    int got[$];
    int nsq, first_div, first_wb, last_wb;

    always #5 clk = ~clk;

    fp_wb_arbiter #(.ID_W(ID_W), .PAYLOAD_W(PW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .div_done(div_done), .div_id(div_id), .div_payload(div_payload), .div_ack(div_ack),
        .sqrt_done(sqrt_done), .sqrt_id(sqrt_id), .sqrt_payload(sqrt_payload), .sqrt_ack(sqrt_ack),
        .wb_done(wb_done), .wb_id(wb_id), .wb_payload(wb_payload), .wb_src(wb_src), .wb_ack(wb_ack)
    );

    function automatic logic [PW-1:0] pay(input bit src, input int id);
        return {(src ? 32'h0000_5157 : 32'h0000_D1F0), 32'(id), 32'hC0DE_0000 + 32'(id * 3)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic apply();
        div_done  = div_q.size() > 0;
        sqrt_done = sqrt_q.size() > 0;
        div_id = '0; div_payload = '0; sqrt_id = '0; sqrt_payload = '0;
        if (div_done) begin
            div_id      = ID_W'(div_q[0]);
            div_payload = pay(0, div_q[0]);
        end
        if (sqrt_done) begin
            sqrt_id      = ID_W'(sqrt_q[0]);
            sqrt_payload = pay(1, sqrt_q[0]);
        end
    endtask

    // one clock: requesters drop whatever was acked at the edge, then present the next result
    task automatic step();
        @(posedge clk);
        #1;
        if (saw_d) void'(div_q.pop_front());
        if (saw_s) void'(sqrt_q.pop_front());
        saw_d = 0;
        saw_s = 0;
        apply();
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            streak = 0;
`ifdef FP_WB_ARB_SKID_EN
            m_full = 0; m_src = 0; m_id = '0; m_pay = '0;
`endif
        end
        any = div_done | sqrt_done;
        ps  = sqrt_done && !(div_done && streak >= LIM);
`ifdef FP_WB_ARB_SKID_EN
        take   = rst && any && (!m_full || wb_ack);
        e_done = m_full; e_src = m_src; e_id = m_id; e_pay = m_pay;
`else
        take   = any && wb_ack;
        e_done = any;
        e_src  = ps;
        e_id   = ps ? sqrt_id : div_id;
        e_pay  = ps ? sqrt_payload : div_payload;
`endif
        chk("wb_done", wb_done, e_done);
        chk("div_ack", div_ack, take && !ps);
        chk("sqrt_ack", sqrt_ack, take && ps);
        if (e_done || !rst) begin
            chk("wb_src", wb_src, e_src);
            chk("wb_id", wb_id, e_id);
            chk("wb_payload", wb_payload, e_pay);
        end
        saw_d = div_ack;
        saw_s = sqrt_ack;
        if (rst) begin
            if (!div_done || (take && !ps)) streak = 0;
            else if (take && ps) streak = (streak + 1 > LIM) ? LIM : streak + 1;
`ifdef FP_WB_ARB_SKID_EN
            if (take) begin
                m_full = 1;
                m_src  = ps;
                m_id   = ps ? sqrt_id : div_id;
                m_pay  = ps ? sqrt_payload : div_payload;
            end else if (wb_ack) begin
                m_full = 0;
            end
`endif
        end
    end

    initial begin
        apply();
        @(negedge clk);
        #1;
        chk("reset_done", wb_done, 0);
        chk("reset_acks", {div_ack, sqrt_ack}, 0);
        chk("reset_id", wb_id, 0);
        chk("reset_payload", wb_payload, 0);
        chk("reset_src", wb_src, 0);
        step();
        rst = 1;

        // sqrt beats div when both arrive together; div stays pending
        div_q.push_back(1);
        sqrt_q.push_back(2);
        wb_ack = 1;
        apply();
        @(negedge clk);
        #1;
        chk("prio_sqrt_ack", sqrt_ack, 1);
        chk("prio_div_ack", div_ack, 0);
`ifdef FP_WB_ARB_SKID_EN
        chk("prio_done_latency", wb_done, 0);
`else
        chk("prio_done", wb_done, 1);
        chk("prio_src", wb_src, 1);
        chk("prio_id", wb_id, 2);
`endif
        step();
        @(negedge clk);
        #1;
        chk("prio_div_next", div_ack, 1);
`ifdef FP_WB_ARB_SKID_EN
        chk("prio_done", wb_done, 1);
        chk("prio_src", wb_src, 1);
        chk("prio_id", wb_id, 2);
`else
        chk("prio_div_src", wb_src, 0);
        chk("prio_div_id", wb_id, 1);
`endif
        repeat (3) step();

        // starvation: div must win after exactly LIM sqrt grants, twice in a row
        for (int i = 0; i < 20; i++) sqrt_q.push_back(i % 8);
        div_q.push_back(6);
        div_q.push_back(7);
        apply();
        dpos.delete();
        nsq = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (div_ack) dpos.push_back(i);
            if (sqrt_ack) nsq++;
            step();
        end
        chk("starve_div_count", dpos.size(), 2);
        chk("starve_div_first", dpos.size() > 0 ? dpos[0] : 99, 4);
        chk("starve_div_second", dpos.size() > 1 ? dpos[1] : 99, 9);
        chk("starve_sqrt_count", nsq, 10);
        repeat (12) step();

        // backpressure: outputs frozen, no acks, starvation count preserved
        for (int i = 0; i < 10; i++) sqrt_q.push_back((3 + i) % 8);
        div_q.push_back(5);
        wb_ack = 0;
        apply();
`ifdef FP_WB_ARB_SKID_EN
        @(negedge clk);
        #1;
        chk("bp_load_ack", sqrt_ack, 1);
        chk("bp_load_done", wb_done, 0);
        step();
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_done", wb_done, 1);
            chk("bp_id", wb_id, 3);
            chk("bp_src", wb_src, 1);
            chk("bp_payload", wb_payload, pay(1, 3));
            chk("bp_no_ack", {div_ack, sqrt_ack}, 0);
            step();
        end
        wb_ack = 1;
        first_div = 99;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (div_ack && first_div == 99) first_div = i;
            step();
        end
        chk("bp_starve_kept", first_div, EXP_BP_DIV);
        repeat (10) step();

        // back-to-back div results, no bubbles
        for (int i = 0; i < 8; i++) div_q.push_back(i);
        apply();
        got.delete();
        first_wb = 99;
        last_wb = 99;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (wb_done) begin
                got.push_back(int'(wb_id));
                if (first_wb == 99) first_wb = i;
                last_wb = i;
            end
            step();
        end
        chk("tp_count", got.size(), 8);
        chk("tp_first", first_wb, EXP_TP_FIRST);
        chk("tp_last", last_wb, EXP_TP_FIRST + 7);
        for (int k = 0; k < 8; k++) chk("tp_id", k < got.size() ? got[k] : 99, k);

        // asynchronous reset between edges
        sqrt_q.push_back(5);
        wb_ack = 0;
        apply();
`ifdef FP_WB_ARB_SKID_EN
        @(negedge clk);
        #1;
        chk("rs_load_ack", sqrt_ack, 1);
        step();
`endif
        @(negedge clk);
        #1;
        chk("rs_pre_done", wb_done, 1);
        chk("rs_pre_id", wb_id, 5);
        #1;
        rst = 0;
        #1;
`ifdef FP_WB_ARB_SKID_EN
        chk("rs_done", wb_done, 0);
        chk("rs_id", wb_id, 0);
        chk("rs_payload", wb_payload, 0);
        chk("rs_src", wb_src, 0);
`else
        chk("rs_comb_done", wb_done, 1);
        chk("rs_comb_id", wb_id, 5);
`endif
        step();
        step();
        rst = 1;
        div_q.push_back(2);
        wb_ack = 1;
        apply();
        @(negedge clk);
        #1;
`ifdef FP_WB_ARB_SKID_EN
        chk("rs_first_ack", div_ack, 1);
        step();
        @(negedge clk);
        #1;
        chk("rs_first_done", wb_done, 1);
        chk("rs_first_id", wb_id, 2);
        chk("rs_first_src", wb_src, 0);
`else
        chk("rs_first_ack", sqrt_ack, 1);
        chk("rs_first_id", wb_id, 5);
        step();
        @(negedge clk);
        #1;
        chk("rs_second_ack", div_ack, 1);
        chk("rs_second_id", wb_id, 2);
`endif
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameter ID_W, default 3, SHALL be the width of the instruction ID carried by each requester.
REQ-002 Parameter PAYLOAD_W, default 96, SHALL be the width of the opaque intermediate-writeback payload (rd, fflags, rm, grs, clz, shift fields).
REQ-003 Parameter STARVE_LIMIT, default 4, range 1..15, SHALL be the number of consecutive sqrt grants after which a pending div request wins.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Ports div_done / sqrt_done, input, 1 bit each: the requester holds a valid result.
REQ-007 Ports div_id / sqrt_id, input, ID_W bits each: the result ID.
REQ-008 Ports div_payload / sqrt_payload, input, PAYLOAD_W bits each: the result payload.
REQ-009 Ports div_ack / sqrt_ack, output, 1 bit each: the result is accepted this cycle and the requester drops it.
REQ-010 Port wb_done, output, 1 bit: the shared writeback holds a valid result.
REQ-011 Port wb_id / wb_payload, output, ID_W / PAYLOAD_W bits: the winning result.
REQ-012 Port wb_src, output, 1 bit: source of the result (0 = div, 1 = sqrt).
REQ-013 Port wb_ack, input, 1 bit: the downstream stage consumes wb_* this cycle.

Function
REQ-014 Base priority SHALL be sqrt over div because sqrt has the longer latency.
REQ-015 Counter starve_cnt, 4 bits, SHALL increment, saturating at STARVE_LIMIT, on each sqrt grant made while div_done=1.
REQ-016 starve_cnt SHALL clear on any div grant, and on any cycle with div_done=0.
REQ-017 When starve_cnt==STARVE_LIMIT and div_done=1, div SHALL be granted even if sqrt_done=1.
REQ-018 At most one of div_ack and sqrt_ack SHALL be high in any cycle.
REQ-019 An ack SHALL never be asserted to a requester whose done is low.
REQ-020 The requester SHALL hold id and payload stable from done rising until the cycle of its ack.
REQ-021 With skid enabled (REQ-029), the output register SHALL have two states: EMPTY and FULL.
REQ-022 In EMPTY with any done high: grant per REQ-014/017, ack the winner in the same cycle, load its id, payload and src, and go to FULL.
REQ-023 In FULL with wb_ack=1 and a done high: reload the output in the same cycle (back-to-back, no bubble) and stay in FULL.
REQ-024 In FULL with wb_ack=1 and no done: go to EMPTY.
REQ-025 In FULL with wb_ack=0: hold all wb_* outputs, assert no ack, and leave starve_cnt unchanged.
REQ-026 When both dones are high in EMPTY, the winner SHALL be loaded and the loser SHALL stay pending, not be dropped.
REQ-027 wb_ack asserted while wb_done=0 SHALL be ignored.

Reset
REQ-028 When rst=0, the block SHALL asynchronously force state EMPTY, wb_done=0, wb_src=0, wb_id=0, wb_payload=0, starve_cnt=0, and div_ack=sqrt_ack=0. Normal operation SHALL resume on the first clk edge after rst deasserts; results in flight at reset are discarded.

Configuration
REQ-029 Macro FP_WB_ARB_SKID_EN: when defined, the output register of REQ-021..025 SHALL be present, giving 1-cycle latency from grant to wb_done.
REQ-030 When FP_WB_ARB_SKID_EN is not defined, the path SHALL be combinational with 0-cycle latency:
- wb_done = div_done | sqrt_done;
- wb_* are muxed from the current winner;
- winner ack = wb_ack & grant;
- starve_cnt updates only on acked grants;
- reset affects starve_cnt only.

Verification
REQ-031 Sqrt priority: with skid on, div_done=sqrt_done=1 in EMPTY -> sqrt_ack=1 that cycle, next cycle wb_src=1 and wb_id=sqrt_id; div stays pending.
REQ-032 Starvation: STARVE_LIMIT=4, div_done held at 1, sqrt_done continuously 1, wb_ack=1 -> exactly 4 sqrt grants, then 1 div grant, then starve_cnt=0.
REQ-033 Backpressure: FULL, wb_ack=0 for 5 cycles, both dones high -> wb_* stable, no acks, starve_cnt unchanged.
REQ-034 Back-to-back throughput: div_done=1 for 8 cycles with new IDs 0..7, wb_ack=1 -> 8 consecutive wb_done cycles, IDs 0..7 in order, no bubbles.
REQ-035 Reset mid-operation: FULL with wb_id=5, drop rst to 0 asynchronously between clock edges -> wb_done=0 and wb_id=0 immediately; the first grant after release is correct.
REQ-036 Skid disabled: sqrt_done=1, wb_ack=1 -> wb_done=1 and sqrt_ack=1 in the same cycle.
